// File: rtl/serial_sum_deser.sv
// Receive side of the bit-serial adder. Collects LSB-first sum bits plus the final
// carry into a parallel {carry, sum} word and presents it on a valid/ready port.
module serial_sum_deser #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             s_valid,
    input  logic             s_sum,
    input  logic             s_carry,
    output logic [WIDTH:0]   m_data,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             busy,
    output logic             overrun
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        HOLD  = 2'd2
    } state_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   shreg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            shreg   <= '0;
            m_data  <= '0;
            m_valid <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state <= SHIFT;
                        busy  <= 1'b1;
                        cnt   <= '0;
                        shreg <= '0;
                    end
                end

                SHIFT: begin
                    if (s_valid) begin
                        for (int unsigned i = 0; i < WIDTH; i++) begin
                            if (cnt == CW'(i)) shreg[i] <= s_sum;
                        end
                        // Last bit goes straight into m_data; shreg is not read back for it.
                        if (cnt == LAST) begin
                            m_data  <= {s_carry, s_sum, shreg[WIDTH-2:0]};
                            m_valid <= 1'b1;
                            busy    <= 1'b0;
                            cnt     <= '0;
                            state   <= HOLD;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                end

                HOLD: begin
                    if (s_valid) overrun <= 1'b1;
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        if (start) begin
                            state <= SHIFT;
                            busy  <= 1'b1;
                            cnt   <= '0;
                            shreg <= '0;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    m_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_sum_deser.sv
// Scoreboard bench for serial_sum_deser: expected words are queued as they are
// sent and compared when m_valid rises.
module tb_serial_sum_deser;

    localparam int WIDTH = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic             s_valid;
    logic             s_sum;
    logic             s_carry;
    logic [WIDTH:0]   m_data;
    logic             m_valid;
    logic             m_ready;
    logic             busy;
    logic             overrun;

    int n_checks = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    logic mv_prev = 1'b0;
    logic [WIDTH:0] sb_q[$];

    serial_sum_deser #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .s_valid (s_valid),
        .s_sum   (s_sum),
        .s_carry (s_carry),
        .m_data  (m_data),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .busy    (busy),
        .overrun (overrun)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Scoreboard pop on each new word presented.
    always @(negedge clk) begin
        busy_cnt <= busy_cnt + (busy ? 1 : 0);
        if (m_valid && !mv_prev) begin
            if (sb_q.size() == 0) check("sb_unexpected", 32'd1, 32'd0);
            else check("sb_m_data", 32'(m_data), 32'(sb_q.pop_front()));
        end
        mv_prev <= m_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends one word; gap = idle s_valid cycles between bits; poke_start asserts start with bit 2.
    task automatic send_word(input logic [WIDTH-1:0] bits, input logic c, input int gap,
                             input logic poke_start);
        sb_q.push_back({c, bits});
        start = 1'b1;
        tick();
        start = 1'b0;
        check("busy_after_start", 32'(busy), 32'd1);
        for (int i = 0; i < WIDTH; i++) begin
            if (i > 0) begin
                for (int g = 0; g < gap; g++) begin
                    s_valid = 1'b0;
                    tick();
                end
            end
            check("mv_early", 32'(m_valid), 32'd0);
            s_valid = 1'b1;
            s_sum   = bits[i];
            s_carry = (i == WIDTH - 1) ? c : ~c;
            start   = poke_start && (i == 2);
            tick();
            start   = 1'b0;
        end
        s_valid = 1'b0;
        s_sum   = 1'b0;
        s_carry = 1'b0;
        check("mv_after_last", 32'(m_valid), 32'd1);
        check("busy_after_last", 32'(busy), 32'd0);
    endtask

    task automatic handshake();
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        check("mv_drop", 32'(m_valid), 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_sum = 1'b0; s_carry = 1'b0; m_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        check("rst_m_data", 32'(m_data), 32'd0);
        check("rst_m_valid", 32'(m_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);

        // 1: 9+5, no gaps; busy exactly four cycles
        tick();
        busy_cnt = 0;
        send_word(4'b1110, 1'b0, 0, 1'b0);
        check("t1_m_data", 32'(m_data), 32'b01110);
        handshake();
        check("t1_busy_cycles", 32'(busy_cnt), 32'd4);

        // 2: 15+15 with two-cycle gaps
        send_word(4'b1110, 1'b1, 2, 1'b0);
        check("t2_m_data", 32'(m_data), 32'b11110);

        // 3: backpressure and overrun during HOLD
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t3_hold_valid", 32'(m_valid), 32'd1);
            check("t3_hold_data", 32'(m_data), 32'b11110);
        end
        check("t3_no_overrun", 32'(overrun), 32'd0);
        s_valid = 1'b1; s_sum = 1'b1; s_carry = 1'b0;
        tick();
        s_valid = 1'b0; s_sum = 1'b0;
        check("t3_overrun", 32'(overrun), 32'd1);
        check("t3_data_kept", 32'(m_data), 32'b11110);
        check("t3_valid_kept", 32'(m_valid), 32'd1);
        handshake();
        check("t3_idle_busy", 32'(busy), 32'd0);
        check("t3_data_after_hs", 32'(m_data), 32'b11110);
        check("t3_overrun_sticky", 32'(overrun), 32'd1);

        // 4: back-to-back words, start together with handshake
        send_word(4'b0101, 1'b1, 1, 1'b0);
        check("t4_first", 32'(m_data), 32'b10101);
        tick();
        m_ready = 1'b1;
        send_word(4'b0001, 1'b0, 0, 1'b0);
        m_ready = 1'b0;
        check("t4_second", 32'(m_data), 32'b00001);
        handshake();

        // 5: reset mid-word
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_valid = 1'b1; s_sum = 1'b1; tick();
        end
        s_valid = 1'b0; s_sum = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        check("t5_m_data", 32'(m_data), 32'd0);
        check("t5_m_valid", 32'(m_valid), 32'd0);
        check("t5_busy", 32'(busy), 32'd0);
        check("t5_overrun", 32'(overrun), 32'd0);
        send_word(4'b1111, 1'b0, 0, 1'b0);
        check("t5_m_data_fresh", 32'(m_data), 32'b01111);
        check("t5_overrun_clear", 32'(overrun), 32'd0);
        handshake();

        // 6: s_valid in IDLE ignored, start during SHIFT ignored
        for (int k = 0; k < 3; k++) begin
            s_valid = 1'b1; s_sum = 1'b1; s_carry = 1'b1; tick();
            check("t6_idle_busy", 32'(busy), 32'd0);
            check("t6_idle_valid", 32'(m_valid), 32'd0);
        end
        s_valid = 1'b0; s_sum = 1'b0; s_carry = 1'b0;
        check("t6_idle_data", 32'(m_data), 32'b01111);
        check("t6_idle_overrun", 32'(overrun), 32'd0);
        send_word(4'b1010, 1'b1, 1, 1'b1);
        check("t6_m_data", 32'(m_data), 32'b11010);
        handshake();

        tick(); tick();
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_sum_deser.md
Name: serial_sum_deser

Overview:
- Receive end of the bit-serial adder path: collects the LSB-first sum bit stream and the final carry from the serial full-adder stage.
- Assembles them into a parallel (WIDTH+1)-bit result.
- Presents the result on a valid/ready output port.
- Sits after the fa stage; its output feeds the parallel result/display logic.

Parameters:
- WIDTH, 4, operand width in bits = number of serial sum bits per word; result width is WIDTH+1.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  one-cycle pulse, begins collection of a new word
- s_valid  input  1  s_sum (and s_carry on the last bit) valid this cycle
- s_sum  input  1  serial sum bit, LSB first
- s_carry  input  1  adder carry-out; sampled only with the last (WIDTH-th) bit
- m_data  output  WIDTH+1  assembled result {carry, sum[WIDTH-1:0]}
- m_valid  output  1  m_data holds a complete word
- m_ready  input  1  downstream accepts m_data
- busy  output  1  high while in SHIFT
- overrun  output  1  sticky error flag

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state is updated on posedge clk only; rst is sampled on posedge clk and overrides all other inputs.
- Reset values:
  - state=IDLE, bit counter=0, shift register=0
  - m_data=0, m_valid=0, busy=0, overrun=0
- Counter: $clog2(WIDTH)+1 bits wide, counts accepted bits 0..WIDTH-1.
- State IDLE:
  - start=1 -> SHIFT; clears shift register and counter.
  - s_valid is ignored.
- State SHIFT (busy=1):
  - Each cycle with s_valid=1: bit[cnt] <= s_sum, cnt <= cnt+1.
  - s_valid=0 cycles are gaps and do not advance; there is no timeout.
  - start while in SHIFT is ignored.
  - On s_valid=1 with cnt==WIDTH-1:
    - store the last bit;
    - m_data <= {s_carry, bits with s_sum at [WIDTH-1]};
    - m_valid <= 1; counter -> 0; state -> HOLD.
  - m_valid rises the cycle after the last bit; there is no combinational path from s_* to m_*.
- State HOLD (m_valid=1):
  - m_data is held stable until handshake.
  - Handshake = m_valid & m_ready on a rising edge. On handshake, m_valid <= 0 next cycle.
    - If start=1 in the same cycle -> SHIFT (back-to-back words, no idle cycle).
    - Else -> IDLE.
  - start without handshake is ignored.
  - s_valid=1 while in HOLD: data is dropped and overrun <= 1.
- overrun is sticky and clears only on rst.
- m_data keeps its last value after the handshake until the next completed word overwrites it.
- Reset mid-word or mid-HOLD: partial bits are discarded, m_valid drops the next cycle, state returns to IDLE.
- The transfer completes only on the WIDTH-th valid bit; there is no early termination.

Test Plan:
1. Reset, start, then s_valid=1 for 4 cycles with s_sum=0,1,1,1 and s_carry=0 on the last bit (9+5) -> m_valid=1 the cycle after the 4th bit; m_data=5'b01110; busy=1 for exactly the 4 shift cycles.
2. 15+15 with bits 0,1,1,1, s_carry=1, gaps of 2 idle s_valid cycles between bits -> m_data=5'b11110; m_valid asserts only after the 4th valid bit.
3. Backpressure: m_ready=0 for 5 cycles after m_valid -> m_data stable and m_valid held. An s_valid pulse during HOLD -> overrun=1 and m_data unchanged. m_ready=1 -> m_valid=0 next cycle.
4. Back-to-back words: assert start in the same cycle as the handshake, then bits 1,0,0,0 with carry 0 -> busy the next cycle with no IDLE gap; second m_data=5'b00001.
5. Reset mid-operation: rst after 2 bits -> all outputs at reset values. A fresh word 1,1,1,1 with carry 0 -> m_data=5'b01111 (no stale bits); overrun=0.
6. Ignored inputs: s_valid pulses in IDLE and start during SHIFT -> no state or counter change, no m_valid, and the result is unaffected.
